// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline stage: state encoding,
// load/store size codes and the bundled payload carried from ALU to memory stage.
package ex_mem_pkg;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b10
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            cout;
    logic            cmp;
    logic [RD_W-1:0] rd;
    logic            wb_en;
    logic            mem_rd;
    logic            mem_wr;
    logic [2:0]      funct3;
    logic [XLEN-1:0] store_data;
  } payload_t;

endpackage

// File: rtl/ex_mem_stage_payload_reg.sv
// Load-enabled payload register with synchronous reset; used for both the
// head and the skid entry of the EX/MEM stage.
module pipe_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM stage: two-entry skid buffer between ALU and memory stage, with
// ex_ready decoded purely from registered state, plus the forwarding bus.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int N    = ex_mem_pkg::XLEN,
  parameter int RD_W = ex_mem_pkg::RD_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [N-1:0]    ex_res,
  input  logic            ex_cout,
  input  logic            ex_cmp,
  input  logic [RD_W-1:0] ex_rd,
  input  logic            ex_wb_en,
  input  logic            ex_mem_rd,
  input  logic            ex_mem_wr,
  input  logic [2:0]      ex_funct3,
  input  logic [N-1:0]    ex_store_data,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [N-1:0]    mem_res,
  output logic            mem_cout,
  output logic            mem_cmp,
  output logic [RD_W-1:0] mem_rd,
  output logic            mem_wb_en,
  output logic            mem_mem_rd,
  output logic            mem_mem_wr,
  output logic [2:0]      mem_funct3,
  output logic [N-1:0]    mem_store_data,
  output logic            fwd_valid,
  output logic [RD_W-1:0] fwd_rd,
  output logic [N-1:0]    fwd_data
);

  state_t   state_q, state_d;
  payload_t in_pay, head_d, head_q, skid_q;
  logic     accept, pop;
  logic     head_load, skid_load, head_from_skid;

  assign in_pay = '{res: ex_res, cout: ex_cout, cmp: ex_cmp, rd: ex_rd,
                    wb_en: ex_wb_en, mem_rd: ex_mem_rd, mem_wr: ex_mem_wr,
                    funct3: ex_funct3, store_data: ex_store_data};

  assign ex_ready  = (state_q != S_FULL);
  assign mem_valid = (state_q != S_EMPTY);
  assign accept    = ex_valid & ex_ready;
  assign pop       = mem_valid & mem_ready;

  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    skid_load      = 1'b0;
    head_from_skid = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d   = S_ONE;
          head_load = 1'b1;
        end
      end
      S_ONE: begin
        if (accept && !pop) begin
          state_d   = S_FULL;
          skid_load = 1'b1;
        end else if (accept && pop) begin
          head_load = 1'b1;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          state_d        = S_ONE;
          head_load      = 1'b1;
          head_from_skid = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush kills everything buffered; suppressing the loads keeps a
    // same-cycle ALU result from ever reaching the head register.
    if (flush) begin
      state_d   = S_EMPTY;
      head_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  assign head_d = head_from_skid ? skid_q : in_pay;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_payload_reg #(.W($bits(payload_t))) u_head (
    .clk  (clk),
    .rst  (rst),
    .load (head_load),
    .d    (head_d),
    .q    (head_q)
  );

  pipe_payload_reg #(.W($bits(payload_t))) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .d    (in_pay),
    .q    (skid_q)
  );

  assign mem_res        = head_q.res;
  assign mem_cout       = head_q.cout;
  assign mem_cmp        = head_q.cmp;
  assign mem_rd         = head_q.rd;
  assign mem_wb_en      = head_q.wb_en;
  assign mem_mem_rd     = head_q.mem_rd;
  assign mem_mem_wr     = head_q.mem_wr;
  assign mem_funct3     = head_q.funct3;
  assign mem_store_data = head_q.store_data;

  // Load results are only addresses here, and x0 is hardwired zero.
  assign fwd_valid = mem_valid & head_q.wb_en & ~head_q.mem_rd & (head_q.rd != '0);
  assign fwd_rd    = head_q.rd;
  assign fwd_data  = head_q.res;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus random traffic, all checked
// against a queue-based FIFO model of the stage.
module tb_ex_mem_stage;
  import ex_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_res = '0;
  logic        ex_cout = 1'b0;
  logic        ex_cmp = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        ex_wb_en = 1'b0;
  logic        ex_mem_rd = 1'b0;
  logic        ex_mem_wr = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_store_data = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_res;
  logic        mem_cout;
  logic        mem_cmp;
  logic [4:0]  mem_rd;
  logic        mem_wb_en;
  logic        mem_mem_rd;
  logic        mem_mem_wr;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_store_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  int checks = 0;
  int failures = 0;
  payload_t model_q[$];

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_res(ex_res), .ex_cout(ex_cout), .ex_cmp(ex_cmp), .ex_rd(ex_rd),
    .ex_wb_en(ex_wb_en), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_funct3(ex_funct3), .ex_store_data(ex_store_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_res(mem_res), .mem_cout(mem_cout), .mem_cmp(mem_cmp), .mem_rd(mem_rd),
    .mem_wb_en(mem_wb_en), .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr),
    .mem_funct3(mem_funct3), .mem_store_data(mem_store_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic payload_t mk(input logic [31:0] res, input logic [4:0] rd,
                                  input logic wb, input logic ld, input logic st,
                                  input logic [2:0] f3);
    payload_t p;
    p = '0;
    p.res = res; p.rd = rd; p.wb_en = wb; p.mem_rd = ld; p.mem_wr = st; p.funct3 = f3;
    p.store_data = ~res;
    p.cout = res[0];
    p.cmp = res[1];
    return p;
  endfunction

  function automatic payload_t rnd_pay();
    payload_t p;
    p.res = $urandom;
    p.cout = 1'($urandom_range(0, 1));
    p.cmp = 1'($urandom_range(0, 1));
    p.rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    p.wb_en = 1'($urandom_range(0, 1));
    p.mem_rd = 1'($urandom_range(0, 1));
    p.mem_wr = 1'($urandom_range(0, 1));
    p.funct3 = 3'($urandom_range(0, 7));
    p.store_data = $urandom;
    return p;
  endfunction

  task automatic check_outputs(input string tag);
    logic exp_fwd;
    chk({tag, ".ex_ready"}, 32'(ex_ready), 32'(model_q.size() < 2));
    chk({tag, ".mem_valid"}, 32'(mem_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      chk({tag, ".mem_res"}, mem_res, model_q[0].res);
      chk({tag, ".mem_cout"}, 32'(mem_cout), 32'(model_q[0].cout));
      chk({tag, ".mem_cmp"}, 32'(mem_cmp), 32'(model_q[0].cmp));
      chk({tag, ".mem_rd"}, 32'(mem_rd), 32'(model_q[0].rd));
      chk({tag, ".mem_wb_en"}, 32'(mem_wb_en), 32'(model_q[0].wb_en));
      chk({tag, ".mem_mem_rd"}, 32'(mem_mem_rd), 32'(model_q[0].mem_rd));
      chk({tag, ".mem_mem_wr"}, 32'(mem_mem_wr), 32'(model_q[0].mem_wr));
      chk({tag, ".mem_funct3"}, 32'(mem_funct3), 32'(model_q[0].funct3));
      chk({tag, ".mem_store_data"}, mem_store_data, model_q[0].store_data);
      exp_fwd = model_q[0].wb_en && !model_q[0].mem_rd && (model_q[0].rd != 0);
      chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(exp_fwd));
      if (exp_fwd) begin
        chk({tag, ".fwd_rd"}, 32'(fwd_rd), 32'(model_q[0].rd));
        chk({tag, ".fwd_data"}, fwd_data, model_q[0].res);
      end
    end else begin
      chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'd0);
    end
  endtask

  // One clock: drive inputs, check current outputs, then advance the model
  // alongside the DUT edge.
  task automatic step(input string tag, input payload_t p, input logic v,
                      input logic mr, input logic fl);
    logic acc, pp;
    ex_valid = v; mem_ready = mr; flush = fl;
    ex_res = p.res; ex_cout = p.cout; ex_cmp = p.cmp; ex_rd = p.rd;
    ex_wb_en = p.wb_en; ex_mem_rd = p.mem_rd; ex_mem_wr = p.mem_wr;
    ex_funct3 = p.funct3; ex_store_data = p.store_data;
    check_outputs(tag);
    acc = v && (model_q.size() < 2);
    pp = mr && (model_q.size() != 0);
    @(posedge clk);
    if (rst || fl) begin
      model_q.delete();
    end else begin
      if (pp) void'(model_q.pop_front());
      if (acc) model_q.push_back(p);
    end
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".mem_valid"}, 32'(mem_valid), 32'd0);
    chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'd0);
    chk({tag, ".ex_ready"}, 32'(ex_ready), 32'd1);
    chk({tag, ".mem_res"}, mem_res, 32'd0);
    chk({tag, ".mem_store_data"}, mem_store_data, 32'd0);
    chk({tag, ".mem_rd"}, 32'(mem_rd), 32'd0);
  endtask

  initial begin
    payload_t idle;
    payload_t p;
    idle = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    check_reset_state("reset");

    // Single forwardable result, popped immediately.
    step("single0", mk(32'h10, 5'd5, 1'b1, 1'b0, 1'b0, F3_LW), 1'b1, 1'b1, 1'b0);
    chk("single.fwd_rd", 32'(fwd_rd), 32'd5);
    step("single1", idle, 1'b0, 1'b1, 1'b0);
    step("single2", idle, 1'b0, 1'b1, 1'b0);

    // Back-pressure: fill to FULL, third entry held off, then drain in order.
    step("bp0", mk(32'd1, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0), 1'b1, 1'b0, 1'b0);
    step("bp1", mk(32'd2, 5'd2, 1'b1, 1'b0, 1'b0, 3'd0), 1'b1, 1'b0, 1'b0);
    chk("bp.ex_ready_full", 32'(ex_ready), 32'd0);
    p = mk(32'd3, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0);
    step("bp2", p, 1'b1, 1'b0, 1'b0);
    step("bp3", p, 1'b1, 1'b1, 1'b0);
    step("bp4", p, 1'b1, 1'b1, 1'b0);
    step("bp5", idle, 1'b0, 1'b1, 1'b0);
    chk("bp.third", mem_res, 32'd3);
    step("bp6", idle, 1'b0, 1'b1, 1'b0);

    // Load address is not forwarded; rd 0 is not forwarded.
    step("ld0", mk(32'h100, 5'd7, 1'b1, 1'b1, 1'b0, F3_LW), 1'b1, 1'b0, 1'b0);
    chk("ld.mem_funct3", 32'(mem_funct3), 32'(F3_LW));
    chk("ld.fwd_valid", 32'(fwd_valid), 32'd0);
    step("rd0_0", mk(32'h55, 5'd0, 1'b1, 1'b0, 1'b0, F3_SW), 1'b1, 1'b1, 1'b0);
    step("rd0_1", idle, 1'b0, 1'b1, 1'b0);
    chk("rd0.fwd_valid", 32'(fwd_valid), 32'd0);

    // Flush while FULL with a competing ALU result.
    step("fl0", mk(32'hA, 5'd10, 1'b1, 1'b0, 1'b0, 3'd0), 1'b1, 1'b0, 1'b0);
    step("fl1", mk(32'hB, 5'd11, 1'b1, 1'b0, 1'b0, 3'd0), 1'b1, 1'b0, 1'b0);
    step("fl2", mk(32'hC, 5'd12, 1'b1, 1'b0, 1'b0, 3'd0), 1'b1, 1'b0, 1'b1);
    chk("flush.mem_valid", 32'(mem_valid), 32'd0);
    chk("flush.ex_ready", 32'(ex_ready), 32'd1);
    step("fl3", idle, 1'b0, 1'b1, 1'b0);

    // Flush in ONE with simultaneous accept and pop.
    step("fo0", mk(32'h21, 5'd4, 1'b1, 1'b0, 1'b0, 3'd0), 1'b1, 1'b0, 1'b0);
    step("fo1", mk(32'h22, 5'd4, 1'b1, 1'b0, 1'b0, 3'd0), 1'b1, 1'b1, 1'b1);
    step("fo2", idle, 1'b0, 1'b1, 1'b0);

    // Full-rate streaming.
    for (int i = 0; i < 16; i++) begin
      step("stream", mk(32'(i), 5'(i + 1), 1'b1, 1'b0, 1'b0, 3'd0), 1'b1, 1'b1, 1'b0);
      chk("stream.ex_ready", 32'(ex_ready), 32'd1);
    end
    step("stream_end", idle, 1'b0, 1'b1, 1'b0);

    // Reset while FULL discards both entries and zeroes payload.
    step("rf0", mk(32'hDEAD, 5'd9, 1'b1, 1'b0, 1'b0, 3'd0), 1'b1, 1'b0, 1'b0);
    step("rf1", mk(32'hBEEF, 5'd9, 1'b1, 1'b0, 1'b0, 3'd0), 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step("rf2", mk(32'hF00D, 5'd9, 1'b1, 1'b0, 1'b0, 3'd0), 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    check_reset_state("rst_full");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", rnd_pay(), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end
    step("rand_end", idle, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline stage directly downstream of the execute-stage ALU.
- Captures the ALU result (Res/Cout/Cmp) together with the instruction's write-back and memory-control fields, and presents them to the memory stage through a valid/ready handshake.
- Two-entry skid buffer, so the ALU side never sees a combinational ready path from the memory side.
- Also drives the forwarding bus that feeds ALU operand selection.

Parameters:
- N, 32, datapath width; matches ALU N.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- flush  input  1  synchronous kill of all buffered entries (branch mispredict / trap).
- ex_valid  input  1  ALU stage presents a valid result this cycle.
- ex_ready  output  1  stage can accept; decoded from state register only.
- ex_res  input  N  ALU Res.
- ex_cout  input  1  ALU Cout.
- ex_cmp  input  1  ALU Cmp.
- ex_rd  input  RD_W  destination register.
- ex_wb_en  input  1  instruction writes rd.
- ex_mem_rd  input  1  load; ex_res is the address.
- ex_mem_wr  input  1  store; ex_res is the address.
- ex_funct3  input  3  load/store size and sign.
- ex_store_data  input  N  store data (rs2 value).
- mem_valid  output  1  head entry valid toward memory stage.
- mem_ready  input  1  memory stage accepts head entry.
- mem_res, mem_cout, mem_cmp, mem_rd, mem_wb_en, mem_mem_rd, mem_mem_wr, mem_funct3, mem_store_data  output  same widths  head entry fields.
- fwd_valid  output  1  head entry result is forwardable.
- fwd_rd  output  RD_W  head rd.
- fwd_data  output  N  head res.

Behaviour:
- Storage: head register (drives all mem_*/fwd_* outputs) and skid register. State: EMPTY, ONE (head only), FULL (head + skid).
- accept = ex_valid & ex_ready. pop = mem_valid & mem_ready.
- ex_ready = (state != FULL). mem_valid = (state != EMPTY).
- Latency: entry accepted at edge t is visible on mem_* after edge t when the stage was EMPTY (1 cycle); after edge t+1 when it was queued behind a popped head.
- Transitions:
  - EMPTY: accept -> ONE; load head.
  - ONE: accept & !pop -> FULL; load skid.
  - ONE: accept & pop -> ONE; load head from input.
  - ONE: !accept & pop -> EMPTY.
  - FULL: pop -> ONE; head <- skid. No accept is possible since ex_ready=0.
- Order is strictly FIFO. No entry is ever dropped or duplicated. Inputs while ex_ready=0 are ignored.
- Payload is captured only on accept. Head payload holds stable while mem_valid=1 & mem_ready=0.
- fwd_valid = mem_valid & mem_wb_en & !mem_mem_rd & (mem_rd != 0). Load addresses are never forwarded; rd 0 is never forwarded.
- flush: next state EMPTY; overrides a same-cycle accept and pop. A pop in the flush cycle is still seen by the memory stage; it is that stage's job to squash.
- rst: priority over flush. Next state EMPTY, all payload registers and outputs 0, mem_valid=0, fwd_valid=0. ex_ready=1 in the first cycle after reset.
- Reset or flush mid-FULL discards both entries. The following cycle must not show stale data as valid.
- Payload is not cleared on pop or flush (don't-care when invalid). Only rst zeroes payload.
- No arithmetic is performed; widths pass through unchanged.

Decomposition:
- Shared package ex_mem_pkg holds:
  - the state encoding (EMPTY=2'b00, ONE=2'b01, FULL=2'b10);
  - RD_W and funct3 constants (LB/LH/LW/LBU/LHU, SB/SH/SW);
  - a packed payload typedef bundling res, cout, cmp, rd, wb_en, mem_rd, mem_wr, funct3, store_data.
- One sub-module is natural: pipe_payload_reg (load-enabled payload register with sync reset), instantiated twice for head and skid.

Test Plan:
- Reset held 2 cycles, then released -> mem_valid=0, fwd_valid=0, ex_ready=1, mem_res=0.
- Single accept of res=0x0000_0010, rd=5, wb_en=1, mem_ready=1 -> next cycle: mem_valid=1, mem_res=0x10, fwd_valid=1, fwd_rd=5, fwd_data=0x10; following cycle mem_valid=0.
- mem_ready=0, three back-to-back ex_valid with res=1,2,3 -> first two accepted, ex_ready=0 after the second, third held off. Then mem_ready=1 -> outputs 1,2,3 in order, no gaps after the third is accepted.
- Load entry res=0x100, rd=7, wb_en=1, mem_rd=1, funct3=010 -> mem_mem_rd=1, mem_funct3=010, fwd_valid=0. Entry with rd=0, wb_en=1 -> fwd_valid=0.
- State FULL (res=0xA, 0xB held), then flush=1 with ex_valid=1 res=0xC -> next cycle mem_valid=0, ex_ready=1, 0xC never appears on mem_res.
- Continuous ex_valid=1 and mem_ready=1 with res incrementing 0..15 -> one result per cycle, order preserved, ex_ready stays 1 throughout.
